// File: rtl/abro_seq_ctrl_if.sv
// Host-side interface of the ABRO sequencer: symbol push, run control, result.
// Build option: ABRO_SEQ_CHECK_EN widens sym_data with an expected-output bit
// and adds the mismatch flag and counter.
//
// Handshake: a symbol transfers on a rising clk edge where sym_valid && sym_ready.
// sym_data must be stable while sym_valid is high; sym_ready does not depend on
// sym_valid. start is a one-cycle request, honoured only while the sequencer is idle.
interface abro_seq_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef ABRO_SEQ_CHECK_EN
    localparam int SYM_W = 3;
`else
    localparam int SYM_W = 2;
`endif

    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             sym_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_count;
`ifdef ABRO_SEQ_CHECK_EN
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_count;

    modport master (output sym_valid, sym_data, start,
                    input  sym_ready, fifo_level, busy, done, hit_count,
                           mismatch, mismatch_count);
    modport slave  (input  sym_valid, sym_data, start,
                    output sym_ready, fifo_level, busy, done, hit_count,
                           mismatch, mismatch_count);
`else
    modport master (output sym_valid, sym_data, start,
                    input  sym_ready, fifo_level, busy, done, hit_count);
    modport slave  (input  sym_valid, sym_data, start,
                    output sym_ready, fifo_level, busy, done, hit_count);
`endif
endinterface

// File: rtl/abro_seq_ctrl.sv
// ABRO sequencer: buffers A/B symbols in a FIFO, then on start resets the
// detector for one cycle and plays the symbols one per slot, counting det_o hits.
// Build option: ABRO_SEQ_CHECK_EN compares det_o with a per-symbol expected bit.
// dbg_state encoding: 0 IDLE, 1 INIT, 2 RUN, 3 GAP, 4 DONE.
module abro_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    parameter int GAP   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    abro_seq_ctrl_if.slave    host,
    output logic              det_rst_n,
    output logic              det_a,
    output logic              det_b,
    input  logic              det_o,
    output logic [2:0]        dbg_state
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
`ifdef ABRO_SEQ_CHECK_EN
    localparam int SYM_W = 3;
`else
    localparam int SYM_W = 2;
`endif
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [3:0]       gap_q, gap_d;
    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [SYM_W-1:0] head;
    logic             push;
`ifdef ABRO_SEQ_CHECK_EN
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
`endif

    assign head = mem_q[rd_q];
    assign push = host.sym_valid && host.sym_ready;

    // Symbol storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= host.sym_data;
        end
    end

    // State, pointers and counters; reset aborts any run and empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            hit_q   <= '0;
            gap_q   <= '0;
`ifdef ABRO_SEQ_CHECK_EN
            mis_q   <= 1'b0;
            mcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lvl_q   <= lvl_d;
            hit_q   <= hit_d;
            gap_q   <= gap_d;
`ifdef ABRO_SEQ_CHECK_EN
            mis_q   <= mis_d;
            mcnt_q  <= mcnt_d;
`endif
        end
    end

    // Next-state: pushes only in IDLE, one pop per RUN cycle, optional idle gap.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        lvl_d   = lvl_q;
        hit_d   = hit_q;
        gap_d   = gap_q;
`ifdef ABRO_SEQ_CHECK_EN
        mis_d   = mis_q;
        mcnt_d  = mcnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (push) begin
                    wr_d  = wr_q + 1'b1;
                    lvl_d = lvl_q + 1'b1;
                end
                if (host.start) begin
                    if (lvl_q != '0) begin
                        state_d = ST_INIT;
                    end else begin
                        state_d = ST_DONE;
                        hit_d   = '0;
                    end
                end
            end
            ST_INIT: begin
                hit_d   = '0;
`ifdef ABRO_SEQ_CHECK_EN
                mis_d   = 1'b0;
                mcnt_d  = '0;
`endif
                state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_d  = rd_q + 1'b1;
                lvl_d = lvl_q - 1'b1;
                if (det_o && (hit_q != CNT_MAX)) begin
                    hit_d = hit_q + 1'b1;
                end
`ifdef ABRO_SEQ_CHECK_EN
                if (det_o != head[2]) begin
                    mis_d = 1'b1;
                    if (mcnt_q != CNT_MAX) begin
                        mcnt_d = mcnt_q + 1'b1;
                    end
                end
`endif
                if (GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else if (lvl_q == LVL_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = (lvl_q != '0) ? ST_RUN : ST_DONE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign host.sym_ready  = (state_q == ST_IDLE) && (lvl_q != LVL_FULL);
    assign host.fifo_level = lvl_q;
    assign host.busy       = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_GAP);
    assign host.done       = (state_q == ST_DONE);
    assign host.hit_count  = hit_q;
`ifdef ABRO_SEQ_CHECK_EN
    assign host.mismatch       = mis_q;
    assign host.mismatch_count = mcnt_q;
`endif
    assign det_rst_n = (state_q != ST_INIT);
    assign det_a     = (state_q == ST_RUN) && head[1];
    assign det_b     = (state_q == ST_RUN) && head[0];
    assign dbg_state = state_q;
endmodule

// File: tb/tb_abro_seq_ctrl.sv
// Bench for abro_seq_ctrl: one instance with GAP=0, one with GAP=2, each driving
// a small ABRO-style detector model (A seen, then AB arms, AB while armed hits,
// A-less B clears). Optional checks for ABRO_SEQ_CHECK_EN builds.
module tb_abro_seq_ctrl;
`ifdef ABRO_SEQ_CHECK_EN
    localparam int SYM_W = 3;
`else
    localparam int SYM_W = 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    abro_seq_ctrl_if #(.DEPTH(8), .CNT_W(8)) h0 ();
    abro_seq_ctrl_if #(.DEPTH(8), .CNT_W(8)) h1 ();

    logic det_rst_n0, det_a0, det_b0, det_o0;
    logic det_rst_n1, det_a1, det_b1, det_o1;
    logic [2:0] dbg0, dbg1;

    abro_seq_ctrl #(.DEPTH(8), .CNT_W(8), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .host(h0.slave),
        .det_rst_n(det_rst_n0), .det_a(det_a0), .det_b(det_b0),
        .det_o(det_o0), .dbg_state(dbg0)
    );
    abro_seq_ctrl #(.DEPTH(8), .CNT_W(8), .GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .host(h1.slave),
        .det_rst_n(det_rst_n1), .det_a(det_a1), .det_b(det_b1),
        .det_o(det_o1), .dbg_state(dbg1)
    );

    // ---------------- detector models ----------------
    logic [1:0] ds0, ds1;
    wire drst0 = det_rst_n0 & rst_n;
    wire drst1 = det_rst_n1 & rst_n;

    always_ff @(posedge clk or negedge drst0) begin
        if (!drst0) ds0 <= 2'd0;
        else case ({det_a0, det_b0})
            2'b01: ds0 <= 2'd0;
            2'b10: if (ds0 == 2'd0) ds0 <= 2'd1;
            2'b11: if (ds0 == 2'd1) ds0 <= 2'd2;
            default: ;
        endcase
    end
    assign det_o0 = (ds0 == 2'd2) && det_a0 && det_b0;

    always_ff @(posedge clk or negedge drst1) begin
        if (!drst1) ds1 <= 2'd0;
        else case ({det_a1, det_b1})
            2'b01: ds1 <= 2'd0;
            2'b10: if (ds1 == 2'd0) ds1 <= 2'd1;
            2'b11: if (ds1 == 2'd1) ds1 <= 2'd2;
            default: ;
        endcase
    end
    assign det_o1 = (ds1 == 2'd2) && det_a1 && det_b1;

    // ---------------- scoreboard / checking ----------------
    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];
    int init_cnt[2];
    int done_cnt[2];
    int run_cnt[2];
    int gap_cnt[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor dut0: order of played symbols against the push queue, event counts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!det_rst_n0) init_cnt[0]++;
            if (h0.done) done_cnt[0]++;
            if (dbg0 == 3'd2) begin
                run_cnt[0]++;
                check("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("sb_order", {det_a0, det_b0}, exp_q.pop_front());
            end
        end
    end

    // Monitor dut1: gap cycles must drive 00.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!det_rst_n1) init_cnt[1]++;
            if (h1.done) done_cnt[1]++;
            if (dbg1 == 3'd2) run_cnt[1]++;
            if (dbg1 == 3'd3) begin
                gap_cnt[1]++;
                check("gap_ab", {det_a1, det_b1}, 2'b00);
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic push0(input logic [2:0] s);
        h0.sym_valid = 1'b1;
        h0.sym_data  = SYM_W'(s);
        if (h0.sym_ready) exp_q.push_back(s[1:0]);
        @(negedge clk);
        h0.sym_valid = 1'b0;
    endtask

    task automatic push1(input logic [2:0] s);
        h1.sym_valid = 1'b1;
        h1.sym_data  = SYM_W'(s);
        @(negedge clk);
        h1.sym_valid = 1'b0;
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 0) h0.start = v;
        else        h1.start = v;
    endtask

    function automatic logic get_done(input int w);
        return (w == 0) ? h0.done : h1.done;
    endfunction

    // Pulse start and return the cycle (1 = cycle after the start edge) of done.
    task automatic start_and_wait(input int w, input bit restart, output int c);
        init_cnt[w] = 0; done_cnt[w] = 0; run_cnt[w] = 0; gap_cnt[w] = 0;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        c = 1;
        while (!get_done(w) && c < 100) begin
            @(negedge clk);
            c++;
            set_start(w, restart && (c == 2));
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        h0.sym_valid = 1'b0; h0.sym_data = '0; h0.start = 1'b0;
        h1.sym_valid = 1'b0; h1.sym_data = '0; h1.start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready",   h0.sym_ready, 1);
        check("rst_level",   h0.fifo_level, 0);
        check("rst_busy",    h0.busy, 0);
        check("rst_done",    h0.done, 0);
        check("rst_hits",    h0.hit_count, 0);
        check("rst_det_rst", det_rst_n0, 1);
        check("rst_det_ab",  {det_a0, det_b0}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // 10,11,11,11 -> two hits, done at t+6
        push0(3'b010); push0(3'b011); push0(3'b011); push0(3'b011);
        check("t1_level", h0.fifo_level, 4);
        start_and_wait(0, 1'b0, c);
        check("t1_done_cyc", c, 6);
        check("t1_hits",     h0.hit_count, 2);
        check("t1_level0",   h0.fifo_level, 0);
        check("t1_init_cnt", init_cnt[0], 1);
        check("t1_run_cnt",  run_cnt[0], 4);
        check("t1_done_cnt", done_cnt[0], 1);

        // 10,11,01,11 -> 01 clears the detector, no hits
        push0(3'b010); push0(3'b011); push0(3'b001); push0(3'b011);
        start_and_wait(0, 1'b0, c);
        check("t2_done_cyc", c, 6);
        check("t2_hits",     h0.hit_count, 0);

        // Three symbols to offset the pointers, then a wrapping full fill
        push0(3'b011); push0(3'b010); push0(3'b001);
        start_and_wait(0, 1'b0, c);
        check("t3a_done_cyc", c, 5);
        check("t3a_hits",     h0.hit_count, 0);

        push0(3'b010); push0(3'b011); push0(3'b011); push0(3'b001);
        push0(3'b010); push0(3'b011); push0(3'b011); push0(3'b000);
        check("t3_full_level", h0.fifo_level, 8);
        check("t3_full_ready", h0.sym_ready, 0);
        push0(3'b011);
        check("t3_9th_level", h0.fifo_level, 8);
        check("t3_q_size",    exp_q.size(), 8);
        start_and_wait(0, 1'b0, c);
        check("t3_done_cyc", c, 10);
        check("t3_hits",     h0.hit_count, 2);
        check("t3_drained",  exp_q.size(), 0);
        check("t3_ready",    h0.sym_ready, 1);

        // Empty FIFO start: done next cycle, detector reset untouched
        start_and_wait(0, 1'b0, c);
        check("t4_done_cyc", c, 1);
        check("t4_hits",     h0.hit_count, 0);
        check("t4_init_cnt", init_cnt[0], 0);

        // start during busy is ignored
        push0(3'b010); push0(3'b011);
        start_and_wait(0, 1'b1, c);
        repeat (3) @(negedge clk);
        check("t5_done_cyc", c, 4);
        check("t5_done_cnt", done_cnt[0], 1);
        check("t5_busy",     h0.busy, 0);
        check("t5_init_cnt", init_cnt[0], 1);

        // Reset in the middle of a run
        push0(3'b010); push0(3'b011); push0(3'b011); push0(3'b011);
        done_cnt[0] = 0;
        h0.start = 1'b1;
        @(negedge clk);
        h0.start = 1'b0;
        @(negedge clk);
        check("t6_mid_busy", h0.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_level",   h0.fifo_level, 0);
        check("t6_rst_busy",    h0.busy, 0);
        check("t6_rst_done",    h0.done, 0);
        check("t6_rst_hits",    h0.hit_count, 0);
        check("t6_rst_det_rst", det_rst_n0, 1);
        check("t6_rst_det_ab",  {det_a0, det_b0}, 2'b00);
        check("t6_rst_ready",   h0.sym_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_done", done_cnt[0], 0);
        check("t6_level",   h0.fifo_level, 0);

        // GAP=2 instance: 10,11,11 -> one hit, done at t+11
        push1(3'b010); push1(3'b011); push1(3'b111);
        check("g_level", h1.fifo_level, 3);
        start_and_wait(1, 1'b0, c);
        check("g_done_cyc", c, 11);
        check("g_hits",     h1.hit_count, 1);
        check("g_gap_cnt",  gap_cnt[1], 6);
        check("g_run_cnt",  run_cnt[1], 3);
        check("g_level0",   h1.fifo_level, 0);
`ifdef ABRO_SEQ_CHECK_EN
        check("m_ok_flag",  h1.mismatch, 0);
        check("m_ok_count", h1.mismatch_count, 0);
        push1(3'b010); push1(3'b011); push1(3'b011);
        start_and_wait(1, 1'b0, c);
        check("m_bad_flag",  h1.mismatch, 1);
        check("m_bad_count", h1.mismatch_count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
